pipe_exe_md: RTL and testbench
==============================

Name: pipe_exe_md

Overview:
Parametrised next-generation EXE stage for the five-stage pipeline. It keeps the combinational ALU/shift/JAL datapath and adds an EXE/MEM output register. It also adds an iterative unsigned multiply/divide unit with HI/LO registers. A blocking pipeline stall is raised while a multiply or divide is in flight.

Parameters:
W, 32, datapath width; power of two, ≥8
RA, 5, GPR address width
LINK_REG, 31, destination register for JAL

Ports:
clk  in  1  clock; all state updates on rising edge
clrn  in  1  asynchronous active-low reset
e_valid  in  1  EXE holds a valid instruction
ejal  in  1  JAL: result = epc4+4, dest = LINK_REG
ealuimm  in  1  ALU operand B = eimm (else eb)
eshift  in  1  ALU operand A = shift amount (else ea)
ealuc  in  3  ALU op code
emdop  in  3  multiply/divide op code
ewreg  in  1  instruction writes a GPR
epc4  in  W  PC+4 of the instruction
ea, eb  in  W  register operands
eimm  in  W  extended immediate
eGPR_org  in  RA  decoded destination register
e_stall  out  1  freeze PC/IF-ID/ID-EXE; combinational
m_valid  out  1  EXE/MEM valid
m_wreg  out  1  EXE/MEM GPR write enable
m_gpr  out  RA  EXE/MEM destination
m_alu  out  W  EXE/MEM result
md_busy  out  1  MD unit not IDLE

Behaviour:
- Reset, asynchronous on clrn=0: m_valid, m_wreg, m_gpr, m_alu, HI, LO = 0; MD state IDLE; counter 0; e_stall=0. Reset mid-operation discards the operation.
- Operand A = eshift ? zero-extend(eimm[10:6]) : ea. Operand B = ealuimm ? eimm : eb.
- ALU codes:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor
  - 101 sll, 110 srl, 111 sra; shifts move B by A[log2(W)-1:0]
  - Results wrap modulo 2^W; no overflow trap.
- MD codes:
  - 000 none
  - 001 MULTU: {HI,LO} = ea*eb
  - 010 DIVU: LO = ea/eb, HI = ea%eb
  - 011 MFHI, 100 MFLO: result = HI/LO, ewreg honoured
  - 101–111 treated as none
- Result priority: ejal > MFHI/MFLO > ALU. Destination = ejal ? LINK_REG : eGPR_org.
- MD FSM:
  - IDLE: when e_valid and op is MULTU/DIVU, e_stall=1, latch operands, counter=0, go to RUN.
  - RUN: e_stall=1; one shift-add / restoring-subtract step per cycle; counter++. At counter==W-1, write HI/LO on that edge and go to DONE.
  - DONE: e_stall=0; the instruction advances; go to IDLE.
  - Stall length is exactly W+1 cycles per MULTU/DIVU. The instruction leaves EXE on the DONE edge.
- DIVU with eb=0: LO = all ones, HI = ea. It still takes the full W+1 stall cycles.
- EXE/MEM register:
  - e_stall=1: load a bubble (m_valid=0, m_wreg=0, m_gpr/m_alu hold).
  - Otherwise: m_valid=e_valid, m_wreg=e_valid&ewreg, m_gpr/m_alu from datapath.
  - MULTU/DIVU retire with m_wreg forced 0.
- MFHI/MFLO immediately after MULTU/DIVU sees updated HI/LO, because the unit blocks the pipeline. No hazard logic is needed.
- The ID stage holds e_* stable while e_stall=1. If inputs change mid-operation, the latched operands are used.

Decomposition:
- Shared package pipe_exe_pkg: ALU op-code constants, MD op-code constants, MD FSM state encoding (IDLE/RUN/DONE).
- Sub-module md_unit_iter: owns operand latches, counter, FSM, HI/LO; exposes start, op, busy, done, hi, lo.
- ALU and muxes stay in the top module.

Test Plan:
- Reset: assert clrn=0 mid-RUN of a DIVU -> all outputs 0, md_busy=0, HI=LO=0 immediately; release -> next MULTU starts from IDLE.
- ADDI: ea=5, eimm=0xFFFFFFFF, ealuimm=1, ealuc=000, ewreg=1, eGPR_org=8 -> next edge m_alu=4, m_gpr=8, m_wreg=1, m_valid=1.
- JAL: epc4=0x00400010, ejal=1 -> m_alu=0x00400014, m_gpr=31.
- MULTU 0x10000*0x30000 at W=32 -> e_stall high exactly 33 cycles with bubbles to MEM. Then MFHI gives m_alu=0x00000003 and MFLO gives 0x00000000.
- DIVU 100/7 -> LO=14, HI=2. DIVU 9/0 -> LO=0xFFFFFFFF, HI=9. Both retire with m_wreg=0.
- SRA: eb=0x80000000, eshift=1, eimm[10:6]=4, ealuc=111 -> m_alu=0xF8000000. Repeat with W=16 to check parametrisation.

Source files
------------

// File: rtl/pipe_exe_md_pkg.sv
// Shared constants for the pipelined EXE stage: ALU and multiply/divide op codes,
// plus the state encoding of the iterative multiply/divide unit.
package pipe_exe_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    localparam logic [2:0] MD_NONE  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIVU  = 3'b010;
    localparam logic [2:0] MD_MFHI  = 3'b011;
    localparam logic [2:0] MD_MFLO  = 3'b100;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    // Ops that occupy the iterative unit; everything else passes straight through.
    function automatic logic is_md_start_op(input logic [2:0] op);
        return (op == MD_MULTU) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/pipe_exe_md_if.sv
// ID/EXE inputs and EXE/MEM outputs of the EXE stage, bundled as one interface.
interface pipe_exe_md_if #(
    parameter int W  = 32,
    parameter int RA = 5
);
    logic          e_valid;
    logic          ejal;
    logic          ealuimm;
    logic          eshift;
    logic [2:0]    ealuc;
    logic [2:0]    emdop;
    logic          ewreg;
    logic [W-1:0]  epc4;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic [W-1:0]  eimm;
    logic [RA-1:0] eGPR_org;
    logic          e_stall;
    logic          m_valid;
    logic          m_wreg;
    logic [RA-1:0] m_gpr;
    logic [W-1:0]  m_alu;
    logic          md_busy;

    modport master (
        output e_valid, ejal, ealuimm, eshift, ealuc, emdop, ewreg,
               epc4, ea, eb, eimm, eGPR_org,
        input  e_stall, m_valid, m_wreg, m_gpr, m_alu, md_busy
    );

    modport slave (
        input  e_valid, ejal, ealuimm, eshift, ealuc, emdop, ewreg,
               epc4, ea, eb, eimm, eGPR_org,
        output e_stall, m_valid, m_wreg, m_gpr, m_alu, md_busy
    );
endinterface

// File: rtl/md_unit_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit, one step per
// cycle over W cycles, holding the architectural HI/LO registers.
module md_unit_iter
    import pipe_exe_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);
    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    md_state_e      state_r;
    logic [CW-1:0]  cnt_r;
    logic           is_div_r;
    logic [W-1:0]   opnd_r;
    logic [2*W-1:0] work_r;
    logic [2*W-1:0] work_next_s;
    logic [W-1:0]   hi_r;
    logic [W-1:0]   lo_r;

    // work_r holds {accumulator, multiplier} for MULTU and {remainder, quotient} for DIVU;
    // opnd_r is the multiplicand or divisor, both taken from b.
    logic [W:0]   mul_sum_s;
    logic [W:0]   div_rr_s;
    logic         div_ge_s;
    logic [W-1:0] div_diff_s;

    assign mul_sum_s  = {1'b0, work_r[2*W-1:W]} + (work_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
    assign div_rr_s   = {work_r[2*W-1:W], work_r[W-1]};
    assign div_ge_s   = (div_rr_s >= {1'b0, opnd_r});
    assign div_diff_s = W'(div_rr_s - {1'b0, opnd_r});

    // Next value of the working register for one iteration step.
    always_comb begin
        work_next_s = work_r;
        if (is_div_r) begin
            work_next_s = {(div_ge_s ? div_diff_s : div_rr_s[W-1:0]), work_r[W-2:0], div_ge_s};
        end else begin
            work_next_s = {mul_sum_s, work_r[W-1:1]};
        end
    end

    // Sequencer: latch operands, iterate W steps, publish HI/LO, then release the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= MD_IDLE;
            cnt_r    <= {CW{1'b0}};
            is_div_r <= 1'b0;
            opnd_r   <= {W{1'b0}};
            work_r   <= {(2*W){1'b0}};
            hi_r     <= {W{1'b0}};
            lo_r     <= {W{1'b0}};
        end else begin
            case (state_r)
                MD_IDLE: begin
                    if (start) begin
                        state_r  <= MD_RUN;
                        cnt_r    <= {CW{1'b0}};
                        is_div_r <= (op == MD_DIVU);
                        opnd_r   <= b;
                        work_r   <= {{W{1'b0}}, a};
                    end
                end
                MD_RUN: begin
                    work_r <= work_next_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (cnt_r == CNT_LAST) begin
                        hi_r    <= work_next_s[2*W-1:W];
                        lo_r    <= work_next_s[W-1:0];
                        state_r <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    state_r <= MD_IDLE;
                end
                default: begin
                    state_r <= MD_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r != MD_IDLE);
    assign done = (state_r == MD_DONE);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/pipe_exe_md.sv
// EXE stage: ALU/shifter/JAL datapath, iterative multiply/divide with HI/LO, and the
// EXE/MEM pipeline register. The pipe is frozen while a MULTU/DIVU is in flight.
module pipe_exe_md
    import pipe_exe_pkg::*;
#(
    parameter int W        = 32,
    parameter int RA       = 5,
    parameter int LINK_REG = 31
) (
    input  logic          clk,
    input  logic          clrn,
    pipe_exe_md_if.slave  ex
);
    localparam int SW = $clog2(W);

    logic [4:0]    sa_s;
    logic [W-1:0]  opa_s;
    logic [W-1:0]  opb_s;
    logic [SW-1:0] shamt_s;
    logic [W-1:0]  alu_s;
    logic [W-1:0]  res_s;
    logic [RA-1:0] dest_s;
    logic          is_md_s;
    logic          md_start_s;
    logic          md_busy_s;
    logic          md_done_s;
    logic [W-1:0]  hi_s;
    logic [W-1:0]  lo_s;
    logic          e_stall_s;

    logic          m_valid_r;
    logic          m_wreg_r;
    logic [RA-1:0] m_gpr_r;
    logic [W-1:0]  m_alu_r;

    assign sa_s    = 5'(ex.eimm >> 3'd6);
    assign shamt_s = opa_s[SW-1:0];

    // Operand selection.
    always_comb begin
        opa_s = ex.ea;
        opb_s = ex.eb;
        if (ex.eshift) begin
            opa_s = {{(W-5){1'b0}}, sa_s};
        end else begin
            opa_s = ex.ea;
        end
        if (ex.ealuimm) begin
            opb_s = ex.eimm;
        end else begin
            opb_s = ex.eb;
        end
    end

    // ALU; arithmetic wraps silently.
    always_comb begin
        alu_s = {W{1'b0}};
        case (ex.ealuc)
            ALU_ADD: alu_s = opa_s + opb_s;
            ALU_SUB: alu_s = opa_s - opb_s;
            ALU_AND: alu_s = opa_s & opb_s;
            ALU_OR:  alu_s = opa_s | opb_s;
            ALU_XOR: alu_s = opa_s ^ opb_s;
            ALU_SLL: alu_s = opb_s << shamt_s;
            ALU_SRL: alu_s = opb_s >> shamt_s;
            ALU_SRA: alu_s = $unsigned($signed(opb_s) >>> shamt_s);
            default: alu_s = {W{1'b0}};
        endcase
    end

    // Result and destination: JAL beats HI/LO moves, which beat the ALU.
    always_comb begin
        res_s  = alu_s;
        dest_s = ex.eGPR_org;
        if (ex.ejal) begin
            res_s  = ex.epc4 + {{(W-3){1'b0}}, 3'd4};
            dest_s = RA'(LINK_REG);
        end else if (ex.emdop == MD_MFHI) begin
            res_s = hi_s;
        end else if (ex.emdop == MD_MFLO) begin
            res_s = lo_s;
        end else begin
            res_s = alu_s;
        end
    end

    assign is_md_s    = is_md_start_op(ex.emdop);
    assign md_start_s = ex.e_valid && is_md_s;
    // Stall covers the accepting IDLE cycle plus every RUN cycle; DONE lets it go.
    assign e_stall_s  = clrn && ((md_start_s && !md_busy_s) || (md_busy_s && !md_done_s));

    md_unit_iter #(.W(W)) u_md (
        .clk   (clk),
        .rst_n (clrn),
        .start (md_start_s),
        .op    (ex.emdop),
        .a     (ex.ea),
        .b     (ex.eb),
        .busy  (md_busy_s),
        .done  (md_done_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    // EXE/MEM register: bubbles while stalled, multiply/divide retire without a GPR write.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            m_valid_r <= 1'b0;
            m_wreg_r  <= 1'b0;
            m_gpr_r   <= {RA{1'b0}};
            m_alu_r   <= {W{1'b0}};
        end else if (e_stall_s) begin
            m_valid_r <= 1'b0;
            m_wreg_r  <= 1'b0;
        end else begin
            m_valid_r <= ex.e_valid;
            m_wreg_r  <= ex.e_valid && ex.ewreg && !is_md_s;
            m_gpr_r   <= dest_s;
            m_alu_r   <= res_s;
        end
    end

    assign ex.e_stall = e_stall_s;
    assign ex.md_busy = md_busy_s;
    assign ex.m_valid = m_valid_r;
    assign ex.m_wreg  = m_wreg_r;
    assign ex.m_gpr   = m_gpr_r;
    assign ex.m_alu   = m_alu_r;

endmodule

// File: tb/tb_pipe_exe_md.sv
// Directed bench for pipe_exe_md: ALU vector table plus multiply/divide, reset and W=16 sequences.
module tb_pipe_exe_md;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    pipe_exe_md_if #(.W(32), .RA(5)) ex ();
    pipe_exe_md_if #(.W(16), .RA(5)) ex16 ();

    pipe_exe_md #(.W(32), .RA(5), .LINK_REG(31)) dut (.clk(clk), .clrn(clrn), .ex(ex));
    pipe_exe_md #(.W(16), .RA(5), .LINK_REG(31)) dut16 (.clk(clk), .clrn(clrn), .ex(ex16));

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        v, jal, aimm, sh;
        logic [2:0]  aluc;
        logic        wreg;
        logic [4:0]  gpr;
        logic [31:0] pc4, a, b, imm, exp_alu;
        logic [4:0]  exp_gpr;
        logic        exp_wreg;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mkv(input logic v, jal, aimm, sh, input logic [2:0] aluc,
                                 input logic wreg, input logic [4:0] gpr,
                                 input logic [31:0] pc4, a, b, imm, exp_alu,
                                 input logic [4:0] exp_gpr, input logic exp_wreg);
        vec_t r;
        r = '{v: v, jal: jal, aimm: aimm, sh: sh, aluc: aluc, wreg: wreg, gpr: gpr,
              pc4: pc4, a: a, b: b, imm: imm, exp_alu: exp_alu,
              exp_gpr: exp_gpr, exp_wreg: exp_wreg};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        ex.e_valid = 1'b0; ex.ejal = 1'b0; ex.ealuimm = 1'b0; ex.eshift = 1'b0;
        ex.ealuc = 3'b000; ex.emdop = 3'b000; ex.ewreg = 1'b0;
        ex.epc4 = 32'h0; ex.ea = 32'h0; ex.eb = 32'h0; ex.eimm = 32'h0; ex.eGPR_org = 5'd0;
    endtask

    // Issue MULTU/DIVU, count stall cycles, scramble operands mid-flight, check the retire.
    task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string nm);
        int stalls = 0;
        int bad = 0;
        ex.e_valid = 1'b1; ex.emdop = op; ex.ea = a; ex.eb = b;
        ex.ewreg = 1'b1; ex.eGPR_org = 5'd7; ex.ealuc = 3'b000;
        #1;
        while (ex.e_stall === 1'b1 && stalls < 100) begin
            stalls++;
            @(posedge clk); #1;
            if (ex.m_valid !== 1'b0 || ex.m_wreg !== 1'b0) bad++;
            if (stalls == 2) begin
                ex.ea = ~a; ex.eb = ~b;
            end
        end
        chk({nm, " stall cycles"}, 64'(stalls), 64'd33);
        chk({nm, " bubbles"}, 64'(bad), 64'd0);
        @(posedge clk); #1;
        chk({nm, " retire valid"}, 64'(ex.m_valid), 64'd1);
        chk({nm, " retire wreg"}, 64'(ex.m_wreg), 64'd0);
        idle_in();
    endtask

    task automatic mf(input logic [2:0] op, input logic [31:0] exp, input string nm);
        ex.e_valid = 1'b1; ex.emdop = op; ex.ewreg = 1'b1; ex.eGPR_org = 5'd10;
        ex.ea = 32'h0000_1234; ex.eb = 32'h0000_0001; ex.ealuc = 3'b000;
        @(posedge clk); #1;
        chk(nm, 64'(ex.m_alu), 64'(exp));
        chk({nm, " wreg"}, 64'(ex.m_wreg), 64'd1);
        idle_in();
    endtask

    initial begin
        int s16;
        //            v  jal aimm sh  aluc    wr gpr   pc4           a             b             imm           exp           eg     ew
        vecs[0]  = mkv(1, 0, 1, 0, 3'b000, 1, 5'd8,  32'h0,        32'h5,        32'h0,        32'hFFFF_FFFF, 32'h4,        5'd8,  1);
        vecs[1]  = mkv(1, 0, 0, 0, 3'b001, 1, 5'd9,  32'h0,        32'h3,        32'h5,        32'h0,         32'hFFFF_FFFE, 5'd9,  1);
        vecs[2]  = mkv(1, 0, 0, 0, 3'b010, 1, 5'd10, 32'h0,        32'hF0F0_1234, 32'h0FF0_FF00, 32'h0,       32'h00F0_1200, 5'd10, 1);
        vecs[3]  = mkv(1, 0, 0, 0, 3'b011, 1, 5'd11, 32'h0,        32'hF000_0000, 32'h0000_000F, 32'h0,       32'hF000_000F, 5'd11, 1);
        vecs[4]  = mkv(1, 0, 0, 0, 3'b100, 1, 5'd12, 32'h0,        32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0,       32'hF0F0_0F0F, 5'd12, 1);
        vecs[5]  = mkv(1, 0, 0, 1, 3'b101, 1, 5'd13, 32'h0,        32'h0,        32'h1,        32'h0000_0100, 32'h10,       5'd13, 1);
        vecs[6]  = mkv(1, 0, 0, 1, 3'b110, 1, 5'd14, 32'h0,        32'h0,        32'h8000_0000, 32'h0000_07C0, 32'h1,       5'd14, 1);
        vecs[7]  = mkv(1, 0, 0, 1, 3'b111, 1, 5'd15, 32'h0,        32'h0,        32'h8000_0000, 32'h0000_0100, 32'hF800_0000, 5'd15, 1);
        vecs[8]  = mkv(1, 1, 0, 0, 3'b000, 1, 5'd0,  32'h0040_0010, 32'h0,       32'h0,        32'h0,         32'h0040_0014, 5'd31, 1);
        vecs[9]  = mkv(1, 0, 0, 0, 3'b000, 0, 5'd16, 32'h0,        32'h1,        32'h2,        32'h0,         32'h3,        5'd16, 0);
        vecs[10] = mkv(0, 0, 0, 0, 3'b000, 1, 5'd17, 32'h0,        32'h1,        32'h2,        32'h0,         32'h3,        5'd17, 0);
        vecs[11] = mkv(1, 0, 0, 1, 3'b101, 1, 5'd18, 32'h0,        32'hFFFF_FFFF, 32'h1,       32'h0000_FFC0, 32'h8000_0000, 5'd18, 1);
        vecs[12] = mkv(1, 0, 0, 0, 3'b000, 1, 5'd19, 32'h0,        32'hFFFF_FFFF, 32'h1,       32'h0,         32'h0,        5'd19, 1);
        vecs[13] = mkv(1, 0, 1, 1, 3'b111, 1, 5'd20, 32'h0,        32'h0,        32'h0,        32'h8000_0100, 32'hF800_0010, 5'd20, 1);

        clrn = 1'b0;
        idle_in();
        ex16.e_valid = 1'b0; ex16.ejal = 1'b0; ex16.ealuimm = 1'b0; ex16.eshift = 1'b0;
        ex16.ealuc = 3'b000; ex16.emdop = 3'b000; ex16.ewreg = 1'b0; ex16.epc4 = 16'h0;
        ex16.ea = 16'h0; ex16.eb = 16'h0; ex16.eimm = 16'h0; ex16.eGPR_org = 5'd0;
        #1;
        chk("reset m_valid", 64'(ex.m_valid), 64'd0);
        chk("reset m_wreg",  64'(ex.m_wreg),  64'd0);
        chk("reset m_gpr",   64'(ex.m_gpr),   64'd0);
        chk("reset m_alu",   64'(ex.m_alu),   64'd0);
        chk("reset md_busy", 64'(ex.md_busy), 64'd0);
        chk("reset e_stall", 64'(ex.e_stall), 64'd0);
        @(posedge clk); #1;
        clrn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            ex.e_valid = vecs[i].v; ex.ejal = vecs[i].jal; ex.ealuimm = vecs[i].aimm;
            ex.eshift = vecs[i].sh; ex.ealuc = vecs[i].aluc; ex.ewreg = vecs[i].wreg;
            ex.eGPR_org = vecs[i].gpr; ex.epc4 = vecs[i].pc4; ex.ea = vecs[i].a;
            ex.eb = vecs[i].b; ex.eimm = vecs[i].imm; ex.emdop = 3'b000;
            @(posedge clk); #1;
            chk($sformatf("v%0d m_valid", i), 64'(ex.m_valid), 64'(vecs[i].v));
            chk($sformatf("v%0d m_wreg", i),  64'(ex.m_wreg),  64'(vecs[i].exp_wreg));
            chk($sformatf("v%0d m_gpr", i),   64'(ex.m_gpr),   64'(vecs[i].exp_gpr));
            chk($sformatf("v%0d m_alu", i),   64'(ex.m_alu),   64'(vecs[i].exp_alu));
        end
        idle_in();

        run_md(3'b001, 32'h0001_0000, 32'h0003_0000, "multu");
        mf(3'b011, 32'h0000_0003, "mfhi after multu");
        mf(3'b100, 32'h0000_0000, "mflo after multu");
        run_md(3'b010, 32'd100, 32'd7, "divu 100/7");
        mf(3'b100, 32'd14, "mflo after divu");
        mf(3'b011, 32'd2, "mfhi after divu");
        run_md(3'b010, 32'd9, 32'd0, "divu 9/0");
        mf(3'b100, 32'hFFFF_FFFF, "mflo div0");
        mf(3'b011, 32'd9, "mfhi div0");

        // Reset in the middle of a divide.
        ex.e_valid = 1'b1; ex.emdop = 3'b010; ex.ea = 32'd100; ex.eb = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        chk("mid-run busy", 64'(ex.md_busy), 64'd1);
        clrn = 1'b0;
        #1;
        chk("mid-reset m_valid", 64'(ex.m_valid), 64'd0);
        chk("mid-reset m_wreg",  64'(ex.m_wreg),  64'd0);
        chk("mid-reset m_gpr",   64'(ex.m_gpr),   64'd0);
        chk("mid-reset m_alu",   64'(ex.m_alu),   64'd0);
        chk("mid-reset md_busy", 64'(ex.md_busy), 64'd0);
        chk("mid-reset e_stall", 64'(ex.e_stall), 64'd0);
        idle_in();
        @(posedge clk); #1;
        clrn = 1'b1;
        mf(3'b011, 32'h0, "mfhi after reset");
        mf(3'b100, 32'h0, "mflo after reset");
        run_md(3'b001, 32'd7, 32'd6, "multu after reset");
        mf(3'b100, 32'd42, "mflo 7*6");

        // W=16 instance: arithmetic shift and a 17-cycle multiply.
        ex16.e_valid = 1'b1; ex16.eshift = 1'b1; ex16.eimm = 16'h0100; ex16.eb = 16'h8000;
        ex16.ealuc = 3'b111; ex16.ewreg = 1'b1; ex16.eGPR_org = 5'd3;
        @(posedge clk); #1;
        chk("w16 sra", 64'(ex16.m_alu), 64'h0000_F800);
        ex16.eshift = 1'b0; ex16.ealuc = 3'b000; ex16.emdop = 3'b001;
        ex16.ea = 16'h00FF; ex16.eb = 16'h0101;
        #1;
        s16 = 0;
        while (ex16.e_stall === 1'b1 && s16 < 100) begin
            s16++;
            @(posedge clk); #1;
        end
        chk("w16 stall cycles", 64'(s16), 64'd17);
        @(posedge clk); #1;
        ex16.emdop = 3'b100;
        @(posedge clk); #1;
        chk("w16 mflo", 64'(ex16.m_alu), 64'h0000_FFFF);
        ex16.emdop = 3'b011;
        @(posedge clk); #1;
        chk("w16 mfhi", 64'(ex16.m_alu), 64'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
